// File: rtl/opcode_fetch.sv
// Instruction fetch stage: reads opcode/prefix/immediate bytes at the PC and hands one
// decoded instruction at a time to the control path over a valid/ready handshake.
module opcode_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic [7:0]            mem_rd_data,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            opcode,
    output logic                  cb_prefix,
    output logic [15:0]           imm,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_CB,
        FETCH_LO,
        FETCH_HI,
        VALID
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_req;
    logic                  r_two_imm;
    logic                  r_valid;
    logic [7:0]            r_opcode;
    logic                  r_cb;
    logic [15:0]           r_imm;
    logic [ADDR_WIDTH-1:0] r_pc_next;

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_take;
    logic [1:0]            w_len;

    // Number of immediate bytes following an unprefixed opcode; undefined opcodes fall to 0.
    function automatic logic [1:0] imm_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
            8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                imm_len = 2'd2;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
            8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6, 8'hF8, 8'hFE:
                imm_len = 2'd1;
            default:
                imm_len = 2'd0;
        endcase
    endfunction

    assign w_pc_inc = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // A byte is only taken while the request is actually presented to memory.
    assign w_take   = r_req && mem_rd_ack;
    assign w_len    = imm_len(mem_rd_data);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= FETCH_OP;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_two_imm <= 1'b0;
            r_valid   <= 1'b0;
            r_opcode  <= 8'h00;
            r_cb      <= 1'b0;
            r_imm     <= 16'h0000;
            r_pc_next <= RESET_PC;
        end else if (pc_load) begin
            r_state <= FETCH_OP;
            r_pc    <= pc_load_val;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (w_take) begin
                        r_pc <= w_pc_inc;
                        if (mem_rd_data == 8'hCB) begin
                            r_cb    <= 1'b1;
                            r_state <= FETCH_CB;
                        end else begin
                            r_opcode  <= mem_rd_data;
                            r_cb      <= 1'b0;
                            r_imm     <= 16'h0000;
                            r_two_imm <= (w_len == 2'd2);
                            if (w_len == 2'd0) begin
                                r_req     <= 1'b0;
                                r_valid   <= 1'b1;
                                r_pc_next <= w_pc_inc;
                                r_state   <= VALID;
                            end else begin
                                r_state <= FETCH_LO;
                            end
                        end
                    end
                end
                FETCH_CB: begin
                    if (w_take) begin
                        r_pc      <= w_pc_inc;
                        r_opcode  <= mem_rd_data;
                        r_imm     <= 16'h0000;
                        r_req     <= 1'b0;
                        r_valid   <= 1'b1;
                        r_pc_next <= w_pc_inc;
                        r_state   <= VALID;
                    end
                end
                FETCH_LO: begin
                    if (w_take) begin
                        r_pc  <= w_pc_inc;
                        r_imm <= {8'h00, mem_rd_data};
                        if (r_two_imm) begin
                            r_state <= FETCH_HI;
                        end else begin
                            r_req     <= 1'b0;
                            r_valid   <= 1'b1;
                            r_pc_next <= w_pc_inc;
                            r_state   <= VALID;
                        end
                    end
                end
                FETCH_HI: begin
                    if (w_take) begin
                        r_pc         <= w_pc_inc;
                        r_imm[15:8]  <= mem_rd_data;
                        r_req        <= 1'b0;
                        r_valid      <= 1'b1;
                        r_pc_next    <= w_pc_inc;
                        r_state      <= VALID;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FETCH_OP;
                    end
                end
                default: begin
                    r_state <= FETCH_OP;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = r_pc;
    assign mem_rd_req  = r_req;
    assign instr_valid = r_valid;
    assign opcode      = r_opcode;
    assign cb_prefix   = r_cb;
    assign imm         = r_imm;
    assign pc_next     = r_pc_next;

endmodule

// File: tb/tb_opcode_fetch.sv
// Directed bench for opcode_fetch: byte-addressed memory model with programmable ack delay.
module tb_opcode_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic [15:0] imm;
    logic [15:0] pc_next;

    logic [7:0]  mem [0:65535];
    int          ack_delay;
    int          wcnt;
    logic [15:0] addr_log [$];
    int          checks;
    int          errors;

    opcode_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .cb_prefix   (cb_prefix),
        .imm         (imm),
        .pc_next     (pc_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory acks after ack_delay waiting cycles; delay 0 acks in the request cycle.
    assign mem_rd_ack  = mem_rd_req && (wcnt >= ack_delay);
    assign mem_rd_data = mem[mem_addr];

    always @(posedge clock) begin
        if (!mem_rd_req || mem_rd_ack) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
        if (mem_rd_req && mem_rd_ack && !reset && !pc_load) addr_log.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        assert (instr_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s: instr_valid observed %b expected 1 within %0d cycles", tag, instr_valid, budget);
        end
    endtask

    task automatic wait_fetch_at(input string tag, input logic [15:0] addr, input int budget);
        int n;
        n = 0;
        while (!(mem_rd_req === 1'b1 && mem_addr === addr) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, {15'd0, mem_rd_req, mem_addr}, {15'd0, 1'b1, addr});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        addr_log.delete();
        reset = 1'b0;
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic        prev_wait;
        logic [15:0] prev_addr;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        pc_load = 1'b0;
        pc_load_val = 16'h0000;
        instr_ready = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset state, sampled while reset is still held
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rst_req",     {31'd0, mem_rd_req},  32'd0);
        chk("rst_opcode",  {24'd0, opcode},      32'h00);
        chk("rst_cb",      {31'd0, cb_prefix},   32'd0);
        chk("rst_imm",     {16'd0, imm},         32'h0000);
        chk("rst_pc_next", {16'd0, pc_next},     32'h0000);
        chk("rst_addr",    {16'd0, mem_addr},    32'h0000);

        // T1: NOP, zero-wait
        addr_log.delete();
        reset = 1'b0;
        wait_valid("t1_valid", 20, cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_opcode",  {24'd0, opcode},    32'h00);
        chk("t1_cb",      {31'd0, cb_prefix}, 32'd0);
        chk("t1_imm",     {16'd0, imm},       32'h0000);
        chk("t1_pc_next", {16'd0, pc_next},   32'h0001);
        chk("t1_req_low", {31'd0, mem_rd_req}, 32'd0);

        // T2: 3-byte JP nn
        mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
        do_reset();
        wait_valid("t2_valid", 20, cyc);
        chk("t2_latency", cyc, 4);
        chk("t2_opcode",  {24'd0, opcode},  32'hC3);
        chk("t2_imm",     {16'd0, imm},     32'h0150);
        chk("t2_pc_next", {16'd0, pc_next}, 32'h0003);
        chk("t2_nreads",  addr_log.size(),  3);
        if (addr_log.size() == 3) begin
            chk("t2_addr0", {16'd0, addr_log[0]}, 32'h0000);
            chk("t2_addr1", {16'd0, addr_log[1]}, 32'h0001);
            chk("t2_addr2", {16'd0, addr_log[2]}, 32'h0002);
        end

        // T3: CB-prefixed followed by 2-byte LD A,n
        mem[0] = 8'hCB; mem[1] = 8'h37; mem[2] = 8'h3E; mem[3] = 8'h42;
        do_reset();
        wait_valid("t3a_valid", 20, cyc);
        chk("t3a_opcode",  {24'd0, opcode},    32'h37);
        chk("t3a_cb",      {31'd0, cb_prefix}, 32'd1);
        chk("t3a_imm",     {16'd0, imm},       32'h0000);
        chk("t3a_pc_next", {16'd0, pc_next},   32'h0002);
        consume();
        chk("t3_bubble_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_bubble_req",   {31'd0, mem_rd_req},  32'd1);
        wait_valid("t3b_valid", 20, cyc);
        chk("t3b_opcode",  {24'd0, opcode},    32'h3E);
        chk("t3b_cb",      {31'd0, cb_prefix}, 32'd0);
        chk("t3b_imm",     {16'd0, imm},       32'h0042);
        chk("t3b_pc_next", {16'd0, pc_next},   32'h0004);

        // T4: 3-cycle ack delay, consumer stalls 5 cycles
        mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
        ack_delay = 3;
        do_reset();
        cyc = 0;
        prev_wait = 1'b0;
        prev_addr = 16'h0000;
        while (instr_valid !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (prev_wait) begin
                chk("t4_req_hold",  {31'd0, mem_rd_req}, 32'd1);
                chk("t4_addr_hold", {16'd0, mem_addr},   {16'd0, prev_addr});
            end
            prev_wait = mem_rd_req && !mem_rd_ack;
            prev_addr = mem_addr;
        end
        chk("t4_valid",   {31'd0, instr_valid}, 32'd1);
        chk("t4_latency", cyc, 13);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t4_hold_valid",   {31'd0, instr_valid}, 32'd1);
            chk("t4_hold_opcode",  {24'd0, opcode},      32'hC3);
            chk("t4_hold_imm",     {16'd0, imm},         32'h1234);
            chk("t4_hold_pc_next", {16'd0, pc_next},     32'h0003);
        end
        consume();
        chk("t4_consumed", {31'd0, instr_valid}, 32'd0);
        ack_delay = 0;

        // T5: PC wraps from FFFF to 0000 inside one instruction
        mem[16'hFFFF] = 8'h3E; mem[0] = 8'hAA;
        do_reset();
        pc_load = 1'b1;
        pc_load_val = 16'hFFFF;
        @(negedge clock);
        pc_load = 1'b0;
        chk("t5_load_addr", {16'd0, mem_addr}, 32'hFFFF);
        wait_valid("t5_valid", 20, cyc);
        chk("t5_opcode",  {24'd0, opcode},  32'h3E);
        chk("t5_imm",     {16'd0, imm},     32'h00AA);
        chk("t5_pc_next", {16'd0, pc_next}, 32'h0001);
        chk("t5_nreads",  addr_log.size(),  2);
        if (addr_log.size() == 2) begin
            chk("t5_addr0", {16'd0, addr_log[0]}, 32'hFFFF);
            chk("t5_addr1", {16'd0, addr_log[1]}, 32'h0000);
        end

        // T6a: redirect while fetching the low immediate byte
        mem[0] = 8'hC3; mem[1] = 8'h11; mem[2] = 8'h22;
        mem[16'hC000] = 8'h00;
        ack_delay = 2;
        do_reset();
        wait_fetch_at("t6_in_lo", 16'h0001, 30);
        addr_log.delete();
        pc_load = 1'b1;
        pc_load_val = 16'hC000;
        @(negedge clock);
        pc_load = 1'b0;
        chk("t6_drop_req",   {31'd0, mem_rd_req},  32'd0);
        chk("t6_drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_drop_addr",  {16'd0, mem_addr},    32'hC000);
        wait_valid("t6_valid", 30, cyc);
        chk("t6_opcode",  {24'd0, opcode},  32'h00);
        chk("t6_pc_next", {16'd0, pc_next}, 32'hC001);
        chk("t6_nreads",  addr_log.size(),  1);
        if (addr_log.size() == 1) chk("t6_addr0", {16'd0, addr_log[0]}, 32'hC000);

        // T6b: reset while fetching the high immediate byte
        mem[16'hC001] = 8'hC3; mem[16'hC002] = 8'h33; mem[16'hC003] = 8'h44;
        consume();
        wait_fetch_at("t6_in_hi", 16'hC003, 40);
        reset = 1'b1;
        @(negedge clock);
        chk("t6r_valid",   {31'd0, instr_valid}, 32'd0);
        chk("t6r_req",     {31'd0, mem_rd_req},  32'd0);
        chk("t6r_opcode",  {24'd0, opcode},      32'h00);
        chk("t6r_imm",     {16'd0, imm},         32'h0000);
        chk("t6r_pc_next", {16'd0, pc_next},     32'h0000);
        chk("t6r_addr",    {16'd0, mem_addr},    32'h0000);
        addr_log.delete();
        reset = 1'b0;
        wait_valid("t6r_valid_after", 30, cyc);
        chk("t6r2_opcode",  {24'd0, opcode},  32'hC3);
        chk("t6r2_imm",     {16'd0, imm},     32'h2211);
        chk("t6r2_pc_next", {16'd0, pc_next}, 32'h0003);
        if (addr_log.size() > 0) chk("t6r2_first_addr", {16'd0, addr_log[0]}, 32'h0000);
        else chk("t6r2_nreads", addr_log.size(), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
